sparse_pe_array: RTL and testbench

Next-generation output-stationary MAC array. MAC_NUM lanes share one streamed weight per beat, and each lane takes its own activation. The array accumulates over a programmable reduction length, then produces one quantised BW_ACT result per lane. Compared with the plain pe_array it adds:
- valid/ready handshakes on input and output;
- an internal length counter;
- zero-weight skipping with a skip counter;
- optional rounding and ReLU before saturation.

It sits between the activation/weight buffers and the output-activation write path.

---
 rtl/sparse_pe_array_pkg.sv | 65 ++++++
 rtl/sparse_pe_array_lane_quant.sv | 22 ++
 rtl/sparse_pe_array.sv | 173 +++++++++++++++++
 tb/tb_sparse_pe_array.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pe_array_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg: shared definitions for the sparse_pe_array output-stationary MAC
// array.
//   - pe_state_t : job FSM states (IDLE, ACCUM, QUANT, OUT)
//   - PE_BW_ACT / PE_BW_ACCU : result and accumulator widths the quantiser
//     is built for (the top-level BW_ACT / BW_ACCU must match these)
//   - SAT_MAX / SAT_MIN : signed result range derived from PE_BW_ACT
//   - sat_q() : round / shift / ReLU / saturate of one accumulator
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int PE_BW_ACT  = 8;
    localparam int PE_BW_ACCU = 32;

    localparam int SAT_MAX = (1 << (PE_BW_ACT - 1)) - 1;
    localparam int SAT_MIN = -(1 << (PE_BW_ACT - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_QUANT = 2'd2,
        ST_OUT   = 2'd3
    } pe_state_t;

    // Quantise one accumulator. All arithmetic is one bit wider than the
    // accumulator so the rounding bias cannot overflow before the shift.
    function automatic logic signed [PE_BW_ACT-1:0] sat_q(
        input logic signed [PE_BW_ACCU-1:0] acc,
        input logic        [7:0]            shift,
        input logic                         round,
        input logic                         relu
    );
        logic signed [PE_BW_ACCU:0] v;
        logic signed [PE_BW_ACCU:0] bias;
        logic signed [PE_BW_ACCU:0] lim_hi;
        logic signed [PE_BW_ACCU:0] lim_lo;
        logic        [7:0]          sh;

        lim_hi = (PE_BW_ACCU + 1)'(SAT_MAX);
        lim_lo = (PE_BW_ACCU + 1)'(SAT_MIN);

        bias = '0;
        if (round && (shift != 8'd0)) begin
            bias = (PE_BW_ACCU + 1)'(1) << (shift - 8'd1);
        end

        v  = (PE_BW_ACCU + 1)'(acc) + bias;
        // Shifting past the accumulator width only replicates the sign bit.
        sh = (shift > 8'(PE_BW_ACCU)) ? 8'(PE_BW_ACCU) : shift;
        v  = v >>> sh;

        if (relu && v[PE_BW_ACCU]) begin
            v = '0;
        end

        if (v > lim_hi) begin
            v = lim_hi;
        end else if (v < lim_lo) begin
            v = lim_lo;
        end

        return v[PE_BW_ACT-1:0];
    endfunction

endpackage

// File: rtl/sparse_pe_array_lane_quant.sv
// ---------------------------------------------------------------------------
// pe_lane_quant: combinational quantiser for one lane of sparse_pe_array.
// Ports:
//   i_acc   : signed accumulator value
//   i_shift : right-shift amount
//   i_round : add half an LSB of the shifted result before shifting
//   i_relu  : clamp negative results to zero
//   o_q     : saturated signed result
// ---------------------------------------------------------------------------
module pe_lane_quant
    import pe_pkg::*;
(
    input  logic [PE_BW_ACCU-1:0] i_acc,
    input  logic [7:0]            i_shift,
    input  logic                  i_round,
    input  logic                  i_relu,
    output logic [PE_BW_ACT-1:0]  o_q
);

    assign o_q = sat_q($signed(i_acc), i_shift, i_round, i_relu);

endmodule

// File: rtl/sparse_pe_array.sv
// ---------------------------------------------------------------------------
// sparse_pe_array: output-stationary MAC array with zero-weight skipping.
// MAC_NUM lanes share one streamed weight per beat; each lane has its own
// activation. After cfg_len beats, every lane's accumulator is rounded,
// shifted, optionally ReLU'd and saturated to one BW_ACT result.
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start, cfg_*          : job start and configuration (latched on start)
//   busy                  : high whenever the FSM is not in IDLE
//   in_valid/in_ready     : input beat handshake; in_act (packed per lane)
//                           and in_wet (shared weight)
//   out_valid/out_ready   : result handshake; out_data packed per lane
//   skip_cnt              : zero-weight beats in the current/last job
//   dbg_state             : current FSM state
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A valid source holds its data stable until
// that edge; ready never depends combinationally on valid.
// ---------------------------------------------------------------------------
module sparse_pe_array
    import pe_pkg::*;
#(
    parameter int MAC_NUM = 4,
    parameter int BW_ACT  = PE_BW_ACT,
    parameter int BW_WET  = 8,
    parameter int BW_ACCU = PE_BW_ACCU,
    parameter int BW_LEN  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [BW_LEN-1:0]           cfg_len,
    input  logic [7:0]                  cfg_shift,
    input  logic                        cfg_round,
    input  logic                        cfg_relu,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MAC_NUM*BW_ACT-1:0]   in_act,
    input  logic [BW_WET-1:0]           in_wet,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MAC_NUM*BW_ACT-1:0]   out_data,
    output logic [BW_LEN-1:0]           skip_cnt,
    output logic [1:0]                  dbg_state
);

    pe_state_t                    r_state;
    logic [BW_LEN-1:0]            r_len;
    logic [BW_LEN-1:0]            r_beat;
    logic [BW_LEN-1:0]            r_skip;
    logic [7:0]                   r_shift;
    logic                         r_round;
    logic                         r_relu;
    logic signed [BW_ACCU-1:0]    r_acc [MAC_NUM];
    logic                         r_busy;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic [MAC_NUM*BW_ACT-1:0]    r_out_data;

    logic signed [BW_ACT+BW_WET-1:0] w_prod [MAC_NUM];
    logic [MAC_NUM*BW_ACT-1:0]       w_q;
    logic                            w_accept;
    logic                            w_last;
    logic                            w_wet_zero;

    assign w_accept   = in_valid && r_in_ready;
    assign w_last     = (r_beat == (r_len - BW_LEN'(1)));
    assign w_wet_zero = (in_wet == '0);

    for (genvar g = 0; g < MAC_NUM; g++) begin : g_lane
        // Full-width signed product; sign-extended into the accumulator.
        assign w_prod[g] = $signed(in_act[g*BW_ACT +: BW_ACT]) * $signed(in_wet);

        pe_lane_quant u_quant (
            .i_acc   (r_acc[g]),
            .i_shift (r_shift),
            .i_round (r_round),
            .i_relu  (r_relu),
            .o_q     (w_q[g*BW_ACT +: BW_ACT])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_beat      <= '0;
            r_skip      <= '0;
            r_shift     <= '0;
            r_round     <= 1'b0;
            r_relu      <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int n = 0; n < MAC_NUM; n++) begin
                r_acc[n] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len   <= cfg_len;
                        r_shift <= cfg_shift;
                        r_round <= cfg_round;
                        r_relu  <= cfg_relu;
                        r_beat  <= '0;
                        r_skip  <= '0;
                        r_busy  <= 1'b1;
                        for (int n = 0; n < MAC_NUM; n++) begin
                            r_acc[n] <= '0;
                        end
                        // A zero-length job goes straight to quantising the
                        // cleared accumulators, producing all-zero results.
                        if (cfg_len != '0) begin
                            r_state    <= ST_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state    <= ST_QUANT;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (w_accept) begin
                        if (!w_wet_zero) begin
                            for (int n = 0; n < MAC_NUM; n++) begin
                                r_acc[n] <= r_acc[n] + BW_ACCU'(w_prod[n]);
                            end
                        end else begin
                            r_skip <= r_skip + BW_LEN'(1);
                        end
                        r_beat <= r_beat + BW_LEN'(1);
                        if (w_last) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_QUANT;
                        end
                    end
                end

                ST_QUANT: begin
                    r_out_data  <= w_q;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end

                ST_OUT: begin
                    // out_data is left untouched so the last result stays
                    // readable after the handshake.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign skip_cnt  = r_skip;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sparse_pe_array.sv
module tb_sparse_pe_array;
    import pe_pkg::*;

    localparam int MAC_NUM = 4;
    localparam int BW_ACT  = 8;
    localparam int BW_WET  = 8;
    localparam int BW_ACCU = 32;
    localparam int BW_LEN  = 16;
    localparam int DW      = MAC_NUM * BW_ACT;

    // ---------------- clock / reset / DUT ----------------
    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              start     = 1'b0;
    logic [BW_LEN-1:0] cfg_len   = '0;
    logic [7:0]        cfg_shift = '0;
    logic              cfg_round = 1'b0;
    logic              cfg_relu  = 1'b0;
    logic              busy;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_act    = '0;
    logic [BW_WET-1:0] in_wet    = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [BW_LEN-1:0] skip_cnt;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    sparse_pe_array #(
        .MAC_NUM (MAC_NUM),
        .BW_ACT  (BW_ACT),
        .BW_WET  (BW_WET),
        .BW_ACCU (BW_ACCU),
        .BW_LEN  (BW_LEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .cfg_round (cfg_round),
        .cfg_relu  (cfg_relu),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wet    (in_wet),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .skip_cnt  (skip_cnt),
        .dbg_state (dbg_state)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] beat_act[256];
    logic [7:0]    beat_wet[256];
    logic [DW-1:0] got_out;

    typedef struct {
        int act;
        int wet;
        int sh;
        bit rnd;
        bit relu;
        int exp;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        reset_n   = 1'b1;
    endtask

    // Reference: exact integer MAC over the non-zero-weight beats, wrapped
    // to 32 bits, then round/shift/relu/clamp with plain arithmetic.
    function automatic logic [DW-1:0] model_job(input int len, input int sh, input bit rnd, input bit relu);
        longint        acc [MAC_NUM];
        longint        v;
        int            s;
        logic [DW-1:0] res;
        res = '0;
        for (int n = 0; n < MAC_NUM; n++) acc[n] = 0;
        for (int b = 0; b < len; b++) begin
            if (beat_wet[b] != 8'd0) begin
                for (int n = 0; n < MAC_NUM; n++) begin
                    acc[n] = longint'(int'(acc[n]
                           + longint'($signed(beat_act[b][n*BW_ACT +: BW_ACT]))
                           * longint'($signed(beat_wet[b]))));
                end
            end
        end
        for (int n = 0; n < MAC_NUM; n++) begin
            v = acc[n];
            if (rnd && sh > 0) v = v + (longint'(1) << (sh - 1));
            s = (sh > BW_ACCU) ? BW_ACCU : sh;
            v = v >>> s;
            if (relu && v < 0) v = 0;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            res[n*BW_ACT +: BW_ACT] = 8'(v);
        end
        return res;
    endfunction

    // gap_mode: 0 = back-to-back, 1 = one idle cycle before every beat,
    // 2 = random idle cycles. hold = cycles out_ready stays low.
    task automatic run_job(input int len, input int sh, input bit rnd, input bit relu,
                           input int gap_mode, input int hold, input bit stall_start);
        logic [DW-1:0] held;
        int            wait_cyc;
        int            skips;
        skips = 0;
        for (int b = 0; b < len; b++) if (beat_wet[b] == 8'd0) skips++;
        exp_q.push_back(model_job(len, sh, rnd, relu));

        cfg_len   = BW_LEN'(len);
        cfg_shift = 8'(sh);
        cfg_round = rnd;
        cfg_relu  = relu;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("busy_after_start", busy, 1);

        for (int b = 0; b < len; b++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_act   = $urandom;
                in_wet   = 8'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_act   = beat_act[b];
            in_wet   = beat_wet[b];
            check("in_ready_beat", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;

        check("out_valid_quant_cycle", out_valid, 0);
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        check("out_latency", wait_cyc, 1);
        if (!out_valid) begin
            void'(exp_q.pop_front());
            do_reset();
            return;
        end

        held = out_data;
        for (int h = 0; h < hold; h++) begin
            if (stall_start) begin
                start   = 1'b1;
                cfg_len = '0;
            end
            check("stall_out_valid", out_valid, 1);
            check("stall_busy", busy, 1);
            check("stall_out_data", out_data, held);
            tick();
        end

        out_ready = 1'b1;
        got_out   = out_data;
        check("out_data", out_data, exp_q.pop_front());
        check("skip_cnt", skip_cnt, skips);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("out_valid_fall", out_valid, 0);
        check("busy_fall", busy, 0);
        check("idle_after_out", dbg_state, ST_IDLE);
        check("out_data_hold", out_data, got_out);
        check("skip_cnt_hold", skip_cnt, skips);
    endtask

    task automatic load_test1();
        for (int b = 0; b < 4; b++) begin
            beat_act[b] = {8'd4, 8'd3, 8'd2, 8'd1};
            beat_wet[b] = 8'(b + 1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{act:    3, wet:   1, sh: 1, rnd: 1'b0, relu: 1'b0, exp:    1};
        vecs[1] = '{act:    3, wet:   1, sh: 1, rnd: 1'b1, relu: 1'b0, exp:    2};
        vecs[2] = '{act:   -3, wet:   1, sh: 1, rnd: 1'b0, relu: 1'b0, exp:   -2};
        vecs[3] = '{act:   -3, wet:   1, sh: 1, rnd: 1'b1, relu: 1'b0, exp:   -1};
        vecs[4] = '{act:  127, wet: 127, sh: 0, rnd: 1'b0, relu: 1'b0, exp:  127};
        vecs[5] = '{act: -128, wet: 127, sh: 0, rnd: 1'b0, relu: 1'b0, exp: -128};
        vecs[6] = '{act: -128, wet: 127, sh: 7, rnd: 1'b0, relu: 1'b0, exp: -127};
        vecs[7] = '{act: -128, wet: 127, sh: 7, rnd: 1'b0, relu: 1'b1, exp:    0};
        vecs[8] = '{act:  100, wet:  -3, sh: 2, rnd: 1'b1, relu: 1'b0, exp:  -75};

        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_skip_cnt", skip_cnt, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // Basic job
        load_test1();
        run_job(4, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("t1_result", got_out, {8'd40, 8'd30, 8'd20, 8'd10});

        // Zero skipping
        beat_wet[0] = 8'd0; beat_wet[1] = 8'd5; beat_wet[2] = 8'd0;
        beat_wet[3] = 8'd0; beat_wet[4] = 8'd2; beat_wet[5] = 8'd0;
        for (int b = 0; b < 6; b++) beat_act[b] = {8'd0, 8'd0, 8'hff, 8'd3};
        run_job(6, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("t2_lane0", got_out[7:0], 8'd21);
        check("t2_skip", skip_cnt, 4);

        // Rounding / saturation / ReLU table
        for (int i = 0; i < 9; i++) begin
            beat_act[0] = {4{8'(vecs[i].act)}};
            beat_wet[0] = 8'(vecs[i].wet);
            run_job(1, vecs[i].sh, vecs[i].rnd, vecs[i].relu, 0, 0, 1'b0);
            check($sformatf("vec%0d", i), got_out, {4{8'(vecs[i].exp)}});
        end

        // Handshake stress: gapped input, stalled output, ignored starts
        load_test1();
        run_job(4, 0, 1'b0, 1'b0, 1, 5, 1'b1);
        check("t5_result", got_out, {8'd40, 8'd30, 8'd20, 8'd10});

        // Reset mid-job
        cfg_len   = 16'd4;
        cfg_shift = 8'd0;
        cfg_round = 1'b0;
        cfg_relu  = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_act   = beat_act[b];
            in_wet   = beat_wet[b];
            tick();
        end
        in_valid = 1'b0;
        check("mid_skip_pre", busy, 1);
        do_reset();
        check("mid_rst_state", dbg_state, ST_IDLE);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_skip", skip_cnt, 0);

        load_test1();
        run_job(4, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        check("t6_rerun", got_out, {8'd40, 8'd30, 8'd20, 8'd10});

        run_job(0, 3, 1'b1, 1'b0, 0, 0, 1'b0);
        check("t6_len0", got_out, 0);
        check("t6_len0_skip", skip_cnt, 0);

        // Randomised jobs against the reference model
        for (int j = 0; j < 25; j++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                beat_act[b] = $urandom;
                beat_wet[b] = ($urandom_range(0, 9) < 3) ? 8'd0 : 8'($urandom);
            end
            run_job(len, $urandom_range(0, 20), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
